// File: rtl/mmult_pkg.sv
// Shared definitions for the 3x3 matrix-multiply arbiter: widths, FSM encoding
// and packed-matrix slice helpers.
package mmult_pkg;

  localparam int MM_DW      = 8;
  localparam int MM_CW      = 18;
  localparam int MM_ELEMS   = 9;
  localparam int MM_TIMEOUT = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // LSB of requester req_idx's whole matrix inside a per-requester packed bus.
  function automatic int mat_lsb(input int req_idx, input int elem_w);
    return req_idx * MM_ELEMS * elem_w;
  endfunction

  // LSB of element elem (row-major, element 0 in the top bits) within one matrix.
  function automatic int elem_lsb(input int elem, input int elem_w);
    return (MM_ELEMS - 1 - elem) * elem_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first active request strictly after
// i_last, wrapping around, returned one-hot.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_win,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_win;
  logic               w_found;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(i_last) + k) % NUM_REQ]) begin
        w_win[(int'(i_last) + k) % NUM_REQ] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

  assign o_win = w_win;
  assign o_any = |i_req;

endmodule

// File: rtl/mmult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 3x3 matrix-multiply engine between
// NUM_REQ requesters, with a watchdog on the engine's completion flag.
module mmult_arbiter
  import mmult_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = MM_DW,
  parameter int CW      = MM_CW,
  parameter int TIMEOUT = MM_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*MM_ELEMS*DW-1:0] a_mat,
  input  logic [NUM_REQ*MM_ELEMS*DW-1:0] b_mat,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic [MM_ELEMS*CW-1:0]       c_mat,
  output logic                         busy,
  output logic                         eng_clear,
  output logic                         eng_enable,
  output logic [MM_ELEMS*DW-1:0]       eng_a,
  output logic [MM_ELEMS*DW-1:0]       eng_b,
  input  logic                         eng_valid,
  input  logic [MM_ELEMS*CW-1:0]       eng_c
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int MW = MM_ELEMS * DW;

  logic [1:0]             r_state;
  logic [NUM_REQ-1:0]     r_grant;
  logic [LW-1:0]          r_last;
  logic [WW-1:0]          r_wd;
  logic                   r_err;
  logic [MM_ELEMS*CW-1:0] r_c;
  logic [MW-1:0]          r_a;
  logic [MW-1:0]          r_b;

  logic [NUM_REQ-1:0]     w_win;
  logic                   w_any;
  logic [LW-1:0]          w_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .LW(LW)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_win[i]) w_idx = LW'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LW'(NUM_REQ - 1);
      r_wd    <= '0;
      r_err   <= 1'b0;
      r_c     <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a     <= a_mat[mat_lsb(int'(w_idx), DW) +: MW];
            r_b     <= b_mat[mat_lsb(int'(w_idx), DW) +: MW];
            r_grant <= w_win;
            r_last  <= w_idx;
            r_wd    <= '0;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: r_state <= ST_RUN;
        ST_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (eng_valid) begin
            r_c     <= eng_c;
            r_err   <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_wd == WW'(TIMEOUT - 1)) begin
            // c_mat deliberately keeps the previous result; err marks it stale.
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = (r_state == ST_DONE) ? r_grant : '0;
  assign err        = r_err;
  assign c_mat      = r_c;
  assign busy       = (r_state != ST_IDLE);
  assign eng_clear  = (r_state == ST_CLEAR);
  assign eng_enable = (r_state == ST_RUN);
  assign eng_a      = r_a;
  assign eng_b      = r_b;

endmodule

// File: tb/tb_mmult_arbiter.sv
// Scoreboard bench for mmult_arbiter with a behavioural multiply engine of
// fixed latency that can be forced to never complete.
module tb_mmult_arbiter;

  localparam int NR = 2, DW = 8, CW = 18, TO = 16, ENG_LAT = 2;
  localparam int MW = 9 * DW, CWT = 9 * CW;

  typedef int m9_t [9];
  typedef struct {
    logic [NR-1:0]  done;
    logic           err;
    logic [CWT-1:0] c;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*MW-1:0] a_mat = '0, b_mat = '0;
  logic [NR-1:0] grant, done;
  logic err, busy, eng_clear, eng_enable;
  logic [CWT-1:0] c_mat;
  logic [MW-1:0] eng_a, eng_b;
  logic eng_valid = 1'b0;
  logic [CWT-1:0] eng_c = '0;

  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t e;
  bit oh_bad = 0;
  bit eng_dead = 0;
  int ecnt = 0;
  logic [CWT-1:0] last_c = '0;

  mmult_arbiter #(.NUM_REQ(NR), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .a_mat(a_mat), .b_mat(b_mat),
    .grant(grant), .done(done), .err(err), .c_mat(c_mat), .busy(busy),
    .eng_clear(eng_clear), .eng_enable(eng_enable), .eng_a(eng_a), .eng_b(eng_b),
    .eng_valid(eng_valid), .eng_c(eng_c)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] pk8(input m9_t v);
    logic [MW-1:0] r = '0;
    for (int i = 0; i < 9; i++) r[(8 - i) * DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  function automatic logic [CWT-1:0] pk18(input m9_t v);
    logic [CWT-1:0] r = '0;
    for (int i = 0; i < 9; i++) r[(8 - i) * CW +: CW] = CW'(v[i]);
    return r;
  endfunction

  function automatic logic [CWT-1:0] mmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    m9_t c;
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) begin
        c[r*3+q] = 0;
        for (int k = 0; k < 3; k++)
          c[r*3+q] += int'(a[(8 - (r*3+k)) * DW +: DW]) * int'(b[(8 - (k*3+q)) * DW +: DW]);
      end
    return pk18(c);
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    m9_t v;
    for (int i = 0; i < 9; i++) v[i] = int'($urandom_range(0, 255));
    return pk8(v);
  endfunction

  // Behavioural engine: result valid ENG_LAT enabled cycles after clear.
  always @(posedge clk) begin
    if (reset || eng_clear) begin
      ecnt <= 0;
      eng_valid <= 1'b0;
    end else if (eng_enable && !eng_dead) begin
      ecnt <= ecnt + 1;
      eng_valid <= (ecnt + 1 == ENG_LAT);
      eng_c <= mmul(eng_a, eng_b);
    end else begin
      eng_valid <= 1'b0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!$onehot0(grant)) oh_bad = 1;
    if (done !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected got done=%b err=%b", done, err);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || err !== e.err || c_mat !== e.c) begin
          failures++;
          $display("FAIL done_sb got done=%b err=%b c=%h expected done=%b err=%b c=%h",
                   done, err, c_mat, e.done, e.err, e.c);
        end
      end
    end
  end

  task automatic set_ops(input int idx, input logic [MW-1:0] a, input logic [MW-1:0] b);
    a_mat[idx*MW +: MW] = a;
    b_mat[idx*MW +: MW] = b;
  endtask

  task automatic push(input logic [NR-1:0] d, input logic er, input logic [CWT-1:0] c);
    exp_t x;
    x.done = d; x.err = er; x.c = c;
    sb.push_back(x);
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (done !== '0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_enable(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (eng_enable) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, done, err, busy, eng_clear, eng_enable} !== '0 || c_mat !== '0 ||
        eng_a !== '0 || eng_b !== '0) begin
      failures++;
      $display("FAIL reset_state got grant=%b done=%b err=%b busy=%b clr=%b en=%b c=%h required all zero",
               grant, done, err, busy, eng_clear, eng_enable, c_mat);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    m9_t ia = '{1,0,0,0,1,0,0,0,1};
    m9_t ib = '{1,2,3,4,5,6,7,8,9};
    int cyc; bit ok;
    set_ops(0, pk8(ia), pk8(ib));
    push(2'b01, 1'b0, pk18(ib));
    req = 2'b01;
    @(negedge clk);
    checks++;
    if ({grant, busy, eng_clear, eng_enable} !== 5'b01_1_1_0) begin
      failures++;
      $display("FAIL single_cycle1 got grant=%b busy=%b clr=%b en=%b required 01 1 1 0",
               grant, busy, eng_clear, eng_enable);
    end
    @(negedge clk);
    checks++;
    if ({eng_clear, eng_enable} !== 2'b01 || eng_a !== pk8(ia) || eng_b !== pk8(ib)) begin
      failures++;
      $display("FAIL single_cycle2 got clr=%b en=%b eng_a=%h required clr=0 en=1 eng_a=%h",
               eng_clear, eng_enable, eng_a, pk8(ia));
    end
    wait_done(cyc, ok);
    req = 2'b00;
    checks++;
    if (!ok || cyc + 2 != 3 + ENG_LAT) begin
      failures++;
      $display("FAIL single_latency got %0d required %0d", cyc + 2, 3 + ENG_LAT);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got grant=%b busy=%b required 00 0", grant, busy);
    end
  endtask

  task automatic test_saturation();
    m9_t f = '{255,255,255,255,255,255,255,255,255};
    m9_t w = '{195075,195075,195075,195075,195075,195075,195075,195075,195075};
    int cyc; bit ok;
    set_ops(0, pk8(f), pk8(f));
    push(2'b01, 1'b0, pk18(w));
    last_c = pk18(w);
    req = 2'b01;
    wait_done(cyc, ok);
    req = 2'b00;
    checks++;
    if (!ok || c_mat[CW-1:0] !== CW'(195075)) begin
      failures++;
      $display("FAIL saturation_c22 got %0d required 195075", c_mat[CW-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [MW-1:0] a0, b0, a1, b1;
    int cyc; bit ok; int ndone = 0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    a0 = rnd_mat(); b0 = rnd_mat(); a1 = rnd_mat(); b1 = rnd_mat();
    set_ops(0, a0, b0); set_ops(1, a1, b1);
    for (int i = 0; i < 2; i++) begin
      push(2'b01, 1'b0, mmul(a0, b0));
      push(2'b10, 1'b0, mmul(a1, b1));
    end
    last_c = mmul(a1, b1);
    oh_bad = 0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc, ok);
      if (ok) ndone++;
    end
    req = 2'b00;
    checks++;
    if (ndone != 4 || oh_bad) begin
      failures++;
      $display("FAIL fairness got done_count=%0d onehot_violation=%0d required 4 0", ndone, oh_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int cyc; bit ok;
    eng_dead = 1;
    set_ops(0, rnd_mat(), rnd_mat());
    push(2'b01, 1'b1, last_c);
    req = 2'b01;
    wait_done(cyc, ok);
    req = 2'b00;
    checks++;
    if (!ok || cyc != TO + 2 || err !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_latency got cycle=%0d err=%b required cycle=%0d err=1", cyc, err, TO + 2);
    end
    eng_dead = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [MW-1:0] a1, b1;
    int cyc; bit ok;
    set_ops(0, rnd_mat(), rnd_mat());
    a1 = rnd_mat(); b1 = rnd_mat();
    set_ops(1, a1, b1);
    req = 2'b01;
    wait_enable(ok);
    reset = 1'b1;
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (!ok || {grant, done, err, busy, eng_clear, eng_enable} !== '0 || c_mat !== '0 || eng_a !== '0) begin
      failures++;
      $display("FAIL midrun_reset got grant=%b done=%b err=%b busy=%b en=%b c=%h required all zero",
               grant, done, err, busy, eng_enable, c_mat);
    end
    reset = 1'b0;
    push(2'b10, 1'b0, mmul(a1, b1));
    last_c = mmul(a1, b1);
    @(negedge clk);
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL midrun_regrant got grant=%b required 10", grant);
    end
    wait_done(cyc, ok);
    req = 2'b00;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrun_done got timeout required done");
    end
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    logic [MW-1:0] a1, b1;
    int cyc; bit ok, ok2; bit seen = 0;
    a1 = rnd_mat(); b1 = rnd_mat();
    set_ops(1, a1, b1);
    push(2'b10, 1'b0, mmul(a1, b1));
    req = 2'b10;
    wait_enable(ok);
    req = 2'b00;
    set_ops(1, rnd_mat(), rnd_mat());
    wait_done(cyc, ok2);
    checks++;
    if (!ok || !ok2 || done !== 2'b10) begin
      failures++;
      $display("FAIL early_drop_done got done=%b required 10", done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (grant !== '0 || busy) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL early_drop_regrant got grant_after_done=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_fairness();
    test_watchdog();
    test_reset_mid_run();
    test_early_drop();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
